// File: rtl/vga_receptor.sv
// VGA sink: samples sync/blank/RGB on the pixel clock, recovers pixel coordinates,
// measures line and frame timing, tracks lock and captures one probe pixel per frame.
module vga_receptor #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_INI       = 144,
  parameter int V_INI       = 34,
  parameter int H_ATIVO     = 640,
  parameter int V_ATIVO     = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clock_25M,
  input  logic        reset,
  input  logic        vga_hsync,
  input  logic        vga_vsync,
  input  logic        vga_blank,
  input  logic [9:0]  vga_r,
  input  logic [9:0]  vga_g,
  input  logic [9:0]  vga_b,
  input  logic [9:0]  sonda_x,
  input  logic [9:0]  sonda_y,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic [9:0]  pixel_r,
  output logic [9:0]  pixel_g,
  output logic [9:0]  pixel_b,
  output logic        pixel_valido,
  output logic        quadro_inicio,
  output logic [10:0] largura_linha,
  output logic [10:0] linhas_quadro,
  output logic        travado,
  output logic [9:0]  sonda_r,
  output logic [9:0]  sonda_g,
  output logic [9:0]  sonda_b,
  output logic        sonda_nova
);

  localparam logic [10:0] CMAX   = 11'h7FF;
  localparam logic [10:0] HB     = 11'(H_INI);
  localparam logic [10:0] HE     = 11'(H_INI + H_ATIVO);
  localparam logic [10:0] VB     = 11'(V_INI);
  localparam logic [10:0] VE     = 11'(V_INI + V_ATIVO);
  localparam logic [10:0] HT     = 11'(H_TOTAL);
  localparam logic [10:0] VT     = 11'(V_TOTAL);
  localparam int          CW     = $clog2(LOCK_FRAMES + 1);
  localparam logic [CW-1:0] LOCK_N = CW'(LOCK_FRAMES);

  typedef struct packed {
    logic        win;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [9:0]  r;
    logic [9:0]  g;
    logic [9:0]  b;
    logic        hit;
    logic        start;
    logic        lpub;
    logic [10:0] llen;
    logic        lbad;
    logic        fpub;
    logic [10:0] flen;
    logic        fgood;
    logic        sat;
  } pipe_t;

  // Stage A: raw input capture plus one sample of sync history
  logic       hs_q, hs_p_q, vs_q, vs_p_q, bl_q;
  logic [9:0] r_q, g_q, b_q, sx_q, sy_q;

  always_ff @(posedge clock_25M) begin
    if (reset) begin
      hs_q   <= 1'b1;
      hs_p_q <= 1'b1;
      vs_q   <= 1'b1;
      vs_p_q <= 1'b1;
      bl_q   <= 1'b0;
      r_q    <= '0;
      g_q    <= '0;
      b_q    <= '0;
      sx_q   <= '0;
      sy_q   <= '0;
    end else begin
      hs_q   <= vga_hsync;
      hs_p_q <= hs_q;
      vs_q   <= vga_vsync;
      vs_p_q <= vs_q;
      bl_q   <= vga_blank;
      r_q    <= vga_r;
      g_q    <= vga_g;
      b_q    <= vga_b;
      sx_q   <= sonda_x;
      sy_q   <= sonda_y;
    end
  end

  // Stage B: sample counters, edge decoding and measurement events
  logic [10:0] j_q, j_d, v_q, v_d, llen, flen;
  logic        armed_q, armed_d, lseen_q, fseen_q, fbad_q, fbad_d;
  logic        hfall, vfall, restart, lpub, lbad;
  pipe_t       p_q, p_d;

  assign hfall   = ~hs_q & hs_p_q;
  assign vfall   = ~vs_q & vs_p_q;
  assign restart = hfall & (armed_q | vfall);
  assign llen    = (j_q == CMAX) ? CMAX : j_q + 11'd1;
  assign flen    = (v_q == CMAX) ? CMAX : v_q + 11'd1;
  assign lpub    = hfall & lseen_q;
  assign lbad    = lpub & (llen != HT);

  always_comb begin
    j_d     = hfall ? 11'd0 : ((j_q == CMAX) ? CMAX : j_q + 11'd1);
    v_d     = v_q;
    if (restart)
      v_d = 11'd0;
    else if (hfall && v_q != CMAX)
      v_d = v_q + 11'd1;
    armed_d = restart ? 1'b0 : (armed_q | vfall);
    fbad_d  = restart ? 1'b0 : (fbad_q | lbad);

    p_d       = '0;
    p_d.win   = (j_d >= HB) && (j_d < HE) && (v_d >= VB) && (v_d < VE) && bl_q;
    p_d.x     = 10'(j_d - HB);
    p_d.y     = 10'(v_d - VB);
    p_d.r     = r_q;
    p_d.g     = g_q;
    p_d.b     = b_q;
    p_d.hit   = (10'(j_d - HB) == sx_q) && (10'(v_d - VB) == sy_q);
    p_d.start = restart;
    p_d.lpub  = lpub;
    p_d.llen  = llen;
    p_d.lbad  = lbad;
    p_d.fpub  = restart & fseen_q;
    p_d.flen  = flen;
    // the line closing at a restart belongs to the frame being judged
    p_d.fgood = (flen == VT) && !fbad_q && !lbad;
    p_d.sat   = (j_d == CMAX) || (v_d == CMAX);
  end

  always_ff @(posedge clock_25M) begin
    if (reset) begin
      j_q     <= '0;
      v_q     <= '0;
      armed_q <= 1'b0;
      lseen_q <= 1'b0;
      fseen_q <= 1'b0;
      fbad_q  <= 1'b0;
      p_q     <= '0;
    end else begin
      j_q     <= j_d;
      v_q     <= v_d;
      armed_q <= armed_d;
      lseen_q <= lseen_q | hfall;
      fseen_q <= fseen_q | restart;
      fbad_q  <= fbad_d;
      p_q     <= p_d;
    end
  end

  // Stage C: lock counter and registered outputs
  logic [CW-1:0] cnt_q, cnt_d;
  logic          trav_d, vld_d;

  always_comb begin
    cnt_d = cnt_q;
    if (p_q.fpub && p_q.fgood && cnt_q != LOCK_N)
      cnt_d = cnt_q + 1'b1;
    if (p_q.lbad || (p_q.fpub && !p_q.fgood) || p_q.sat)
      cnt_d = '0;
  end

  assign trav_d = (cnt_d == LOCK_N);
  assign vld_d  = p_q.win & trav_d;

  always_ff @(posedge clock_25M) begin
    if (reset) begin
      cnt_q         <= '0;
      pixel_x       <= '0;
      pixel_y       <= '0;
      pixel_r       <= '0;
      pixel_g       <= '0;
      pixel_b       <= '0;
      pixel_valido  <= 1'b0;
      quadro_inicio <= 1'b0;
      largura_linha <= '0;
      linhas_quadro <= '0;
      travado       <= 1'b0;
      sonda_r       <= '0;
      sonda_g       <= '0;
      sonda_b       <= '0;
      sonda_nova    <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      travado       <= trav_d;
      pixel_valido  <= vld_d;
      pixel_x       <= vld_d ? p_q.x : '0;
      pixel_y       <= vld_d ? p_q.y : '0;
      pixel_r       <= vld_d ? p_q.r : '0;
      pixel_g       <= vld_d ? p_q.g : '0;
      pixel_b       <= vld_d ? p_q.b : '0;
      quadro_inicio <= p_q.start;
      if (p_q.lpub) largura_linha <= p_q.llen;
      if (p_q.fpub) linhas_quadro <= p_q.flen;
      sonda_nova    <= vld_d & p_q.hit;
      if (vld_d && p_q.hit) begin
        sonda_r <= p_q.r;
        sonda_g <= p_q.g;
        sonda_b <= p_q.b;
      end
    end
  end

endmodule

// File: tb/tb_vga_receptor.sv
// Scoreboard bench for vga_receptor on a shrunken 40x20 raster (20x10 active).
module tb_vga_receptor;

  logic        clock_25M = 1'b0;
  logic        reset;
  logic        vga_hsync, vga_vsync, vga_blank;
  logic [9:0]  vga_r, vga_g, vga_b, sonda_x, sonda_y;
  logic [9:0]  pixel_x, pixel_y, pixel_r, pixel_g, pixel_b;
  logic        pixel_valido, quadro_inicio, travado, sonda_nova;
  logic [10:0] largura_linha, linhas_quadro;
  logic [9:0]  sonda_r, sonda_g, sonda_b;

  vga_receptor #(
    .H_TOTAL(40), .V_TOTAL(20), .H_INI(12), .V_INI(4),
    .H_ATIVO(20), .V_ATIVO(10), .LOCK_FRAMES(2)
  ) dut (
    .clock_25M(clock_25M), .reset(reset),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_blank(vga_blank),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .sonda_x(sonda_x), .sonda_y(sonda_y),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pixel_r(pixel_r), .pixel_g(pixel_g), .pixel_b(pixel_b),
    .pixel_valido(pixel_valido), .quadro_inicio(quadro_inicio),
    .largura_linha(largura_linha), .linhas_quadro(linhas_quadro),
    .travado(travado),
    .sonda_r(sonda_r), .sonda_g(sonda_g), .sonda_b(sonda_b),
    .sonda_nova(sonda_nova)
  );

  always #20 clock_25M = ~clock_25M;

  typedef struct { logic [9:0] x, y, r, g, b; int cyc; } pix_t;
  typedef struct { int lin; int larg; bit trav; int cyc; } fr_t;

  pix_t pq[$];
  pix_t sq[$];
  fr_t  fq[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clock_25M) cyc <= cyc + 1;

  // Monitor: pops expectations whenever the DUT strobes an output
  always @(negedge clock_25M) begin
    pix_t e;
    fr_t  f;
    if (pixel_valido) begin
      checks++;
      if (pq.size() == 0) begin
        errors++;
        $display("FAIL pixel_extra: got (%0d,%0d) rgb %h/%h/%h at cyc %0d, required none",
                 pixel_x, pixel_y, pixel_r, pixel_g, pixel_b, cyc);
      end else begin
        e = pq.pop_front();
        if ({pixel_x, pixel_y, pixel_r, pixel_g, pixel_b} !== {e.x, e.y, e.r, e.g, e.b}) begin
          errors++;
          $display("FAIL pixel: got (%0d,%0d) rgb %h/%h/%h, required (%0d,%0d) rgb %h/%h/%h",
                   pixel_x, pixel_y, pixel_r, pixel_g, pixel_b, e.x, e.y, e.r, e.g, e.b);
        end
        checks++;
        if (cyc != e.cyc) begin
          errors++;
          $display("FAIL pixel_latency: got cyc %0d, required %0d", cyc, e.cyc);
        end
      end
    end
    if (sonda_nova) begin
      checks++;
      if (sq.size() == 0) begin
        errors++;
        $display("FAIL sonda_extra: got %h/%h/%h at cyc %0d, required none",
                 sonda_r, sonda_g, sonda_b, cyc);
      end else begin
        e = sq.pop_front();
        if ({sonda_r, sonda_g, sonda_b, cyc} !== {e.r, e.g, e.b, e.cyc}) begin
          errors++;
          $display("FAIL sonda: got %h/%h/%h cyc %0d, required %h/%h/%h cyc %0d",
                   sonda_r, sonda_g, sonda_b, cyc, e.r, e.g, e.b, e.cyc);
        end
      end
    end
    if (quadro_inicio) begin
      checks++;
      if (fq.size() == 0) begin
        errors++;
        $display("FAIL quadro_extra: got pulse at cyc %0d, required none", cyc);
      end else begin
        f = fq.pop_front();
        if (int'(linhas_quadro) != f.lin || int'(largura_linha) != f.larg ||
            travado !== f.trav || cyc != f.cyc) begin
          errors++;
          $display("FAIL quadro: got lin %0d larg %0d trav %0d cyc %0d, required lin %0d larg %0d trav %0d cyc %0d",
                   linhas_quadro, largura_linha, travado, cyc, f.lin, f.larg, f.trav, f.cyc);
        end
      end
    end
  end

  task automatic check_zero(input string nm);
    checks++;
    if ({pixel_valido, quadro_inicio, travado, sonda_nova} !== 4'b0000) begin
      errors++;
      $display("FAIL %s_flags: got %b, required 0000", nm,
               {pixel_valido, quadro_inicio, travado, sonda_nova});
    end
    checks++;
    if (largura_linha !== 11'd0 || linhas_quadro !== 11'd0) begin
      errors++;
      $display("FAIL %s_meas: got %0d/%0d, required 0/0", nm, largura_linha, linhas_quadro);
    end
    checks++;
    if ({pixel_x, pixel_y, pixel_r, pixel_g, pixel_b} !== 50'd0) begin
      errors++;
      $display("FAIL %s_pixel: got %h, required 0", nm, {pixel_x, pixel_y, pixel_r, pixel_g, pixel_b});
    end
    checks++;
    if ({sonda_r, sonda_g, sonda_b} !== 30'd0) begin
      errors++;
      $display("FAIL %s_sonda: got %h, required 0", nm, {sonda_r, sonda_g, sonda_b});
    end
  endtask

  // One raster frame: hsync low hc 0..5, vsync falls mid-line at vc0 hc20,
  // active hc 12..31 / vc 5..14. trav is the lock expected from this frame's restart.
  task automatic drive_frame(input int lin, input int larg, input bit trav,
                             input int str_vc, input int blk_vc, input int rst_vc);
    bit lk, act, bl;
    int len;
    pix_t e;
    lk = trav;
    for (int vc = 0; vc < 20; vc++) begin
      len = (vc == str_vc) ? 41 : 40;
      if (str_vc >= 0 && vc == str_vc + 1) lk = 1'b0;
      for (int hc = 0; hc < len; hc++) begin
        act       = (hc >= 12) && (hc < 32) && (vc >= 5) && (vc < 15);
        bl        = act && !(vc == blk_vc && hc >= 17 && hc <= 21);
        vga_hsync = (hc >= 6);
        vga_vsync = !((vc == 0 && hc >= 20) || vc == 1 || (vc == 2 && hc < 20));
        vga_blank = bl;
        vga_r     = act ? 10'(hc - 12) : 10'd0;
        vga_g     = act ? 10'(vc - 5)  : 10'd0;
        vga_b     = act ? 10'h155      : 10'd0;
        if (vc == rst_vc && hc == 35) begin
          reset = 1'b1;
          @(posedge clock_25M); #1;
          reset = 1'b0;
          check_zero("mid_reset");
          lk = 1'b0;
        end else begin
          if (vc == 1 && hc == 0) fq.push_back('{lin, larg, trav, cyc + 3});
          if (lk && bl) begin
            e.x = 10'(hc - 12); e.y = 10'(vc - 5);
            e.r = e.x; e.g = e.y; e.b = 10'h155; e.cyc = cyc + 3;
            pq.push_back(e);
            if (e.x == sonda_x && e.y == sonda_y) sq.push_back(e);
          end
          @(posedge clock_25M); #1;
          if (str_vc >= 0 && vc == str_vc + 1 && (hc == 1 || hc == 2)) begin
            checks++;
            if (hc == 1 && (largura_linha !== 11'd40 || travado !== 1'b1)) begin
              errors++;
              $display("FAIL stretch_before: got larg %0d trav %0d, required 40/1", largura_linha, travado);
            end
            if (hc == 2 && (largura_linha !== 11'd41 || travado !== 1'b0)) begin
              errors++;
              $display("FAIL stretch_publish: got larg %0d trav %0d, required 41/0", largura_linha, travado);
            end
          end
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    vga_hsync = 1'b1; vga_vsync = 1'b1; vga_blank = 1'b0;
    vga_r = '0; vga_g = '0; vga_b = '0;
    sonda_x = 10'd3; sonda_y = 10'd2;
    repeat (3) @(posedge clock_25M);
    #1;
    check_zero("reset");
    reset = 1'b0;

    drive_frame(0,  40, 1'b0, -1, -1, -1);
    drive_frame(20, 40, 1'b0, -1, -1, -1);
    drive_frame(20, 40, 1'b1, -1, -1, -1);
    sonda_x = 10'd19; sonda_y = 10'd9;
    drive_frame(20, 40, 1'b1, -1, -1, -1);
    sonda_x = 10'd25; sonda_y = 10'd2;
    drive_frame(20, 40, 1'b1, -1, -1, -1);
    sonda_x = 10'd7;  sonda_y = 10'd3;
    drive_frame(20, 40, 1'b1, -1,  8, -1);
    sonda_x = 10'd0;  sonda_y = 10'd0;
    drive_frame(20, 40, 1'b1,  8, -1, -1);
    sonda_x = 10'd3;  sonda_y = 10'd2;
    drive_frame(20, 40, 1'b0, -1, -1, -1);
    drive_frame(20, 40, 1'b0, -1, -1, -1);
    drive_frame(20, 40, 1'b1, -1, -1, -1);
    drive_frame(20, 40, 1'b1, -1, -1, 10);
    drive_frame(0,  40, 1'b0, -1, -1, -1);
    drive_frame(20, 40, 1'b0, -1, -1, -1);
    drive_frame(20, 40, 1'b1, -1, -1, -1);

    vga_hsync = 1'b1; vga_vsync = 1'b1; vga_blank = 1'b0;
    repeat (6) @(posedge clock_25M);
    #1;
    checks++;
    if (pq.size() != 0) begin
      errors++;
      $display("FAIL pixel_missing: got %0d unconsumed, required 0", pq.size());
    end
    checks++;
    if (sq.size() != 0) begin
      errors++;
      $display("FAIL sonda_missing: got %0d unconsumed, required 0", sq.size());
    end
    checks++;
    if (fq.size() != 0) begin
      errors++;
      $display("FAIL quadro_missing: got %0d unconsumed, required 0", fq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
